// File: rtl/socket_ctrl_pkg.sv
// Shared definitions for the kernel-side socket control register block:
// register offsets, CTRL/STATUS bit positions and the run-control FSM states.
package socket_ctrl_pkg;

    localparam int unsigned CTRL_OFF   = 0;
    localparam int unsigned STATUS_OFF = 1;
    localparam int unsigned CYCLE_OFF  = 2;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    localparam int unsigned STAT_IDLE_BIT = 0;
    localparam int unsigned STAT_BUSY_BIT = 1;
    localparam int unsigned STAT_DONE_BIT = 2;
    localparam int unsigned STAT_WERR_BIT = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/socket_ctrl_regs.sv
// Responder for the cl_ctrl bus: decodes registered requests, holds kernel
// argument registers and runs the kernel start/done handshake with a cycle counter.
module socket_ctrl_regs
    import socket_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_ARGS = 8,
    parameter logic [ADDR_W-1:0] ARG_BASE = 12'h010
) (
    input  logic                       clk,
    input  logic                       socket_reset,
    input  logic [ADDR_W-1:0]          cl_ctrl_addr,
    input  logic                       cl_ctrl_ce,
    input  logic                       cl_ctrl_we,
    input  logic [DATA_W-1:0]          cl_ctrl_d,
    output logic [DATA_W-1:0]          cl_ctrl_q,
    output logic                       cl_done,
    output logic                       kernel_start,
    input  logic                       kernel_done,
    output logic [NUM_ARGS*DATA_W-1:0] kernel_args
);

    state_e            r_state, w_state_next;
    logic [31:0]       r_cycle_cnt;
    logic              r_werr;
    logic              r_kernel_start;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_args [NUM_ARGS];

    logic              w_wr, w_rd;
    logic              w_ctrl_hit, w_status_hit, w_cycle_hit, w_arg_hit;
    logic [ADDR_W-1:0] w_arg_off;
    logic              w_start_req, w_clear_req, w_status_rd, w_start_go;
    logic [DATA_W-1:0] w_arg_rdata;
    logic [31:0]       w_status;
    logic [DATA_W-1:0] w_rdata;

    // Full-width decode; the subtraction is only meaningful once addr >= ARG_BASE.
    assign w_wr         = cl_ctrl_ce & cl_ctrl_we;
    assign w_rd         = cl_ctrl_ce & ~cl_ctrl_we;
    assign w_ctrl_hit   = (cl_ctrl_addr == ADDR_W'(CTRL_OFF));
    assign w_status_hit = (cl_ctrl_addr == ADDR_W'(STATUS_OFF));
    assign w_cycle_hit  = (cl_ctrl_addr == ADDR_W'(CYCLE_OFF));
    assign w_arg_off    = cl_ctrl_addr - ARG_BASE;
    assign w_arg_hit    = (cl_ctrl_addr >= ARG_BASE) && (w_arg_off < ADDR_W'(NUM_ARGS));

    assign w_start_req  = w_wr & w_ctrl_hit & cl_ctrl_d[CTRL_START_BIT];
    assign w_clear_req  = w_wr & w_ctrl_hit & cl_ctrl_d[CTRL_CLEAR_BIT];
    assign w_status_rd  = w_rd & w_status_hit;

    // State register
    always_ff @(posedge clk) begin
        if (socket_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; kernel_done takes priority over a start write in RUN.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_start_req) w_state_next = StRun;
            StRun:  if (kernel_done) w_state_next = StDone;
            StDone: begin
                if (w_start_req) begin
                    w_state_next = StRun;
                end else if (w_status_rd) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output / decode logic
    always_comb begin
        w_start_go = w_start_req & (r_state != StRun);
        cl_done    = (r_state == StDone);

        w_status                = '0;
        w_status[STAT_IDLE_BIT] = (r_state == StIdle);
        w_status[STAT_BUSY_BIT] = (r_state == StRun);
        w_status[STAT_DONE_BIT] = (r_state == StDone);
        w_status[STAT_WERR_BIT] = r_werr;

        w_arg_rdata = '0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            if (w_arg_off == ADDR_W'(i)) w_arg_rdata = r_args[i];
        end

        w_rdata = '0;
        if (w_status_hit) begin
            w_rdata = DATA_W'(w_status);
        end else if (w_cycle_hit) begin
            w_rdata = DATA_W'(r_cycle_cnt);
        end else if (w_arg_hit) begin
            w_rdata = w_arg_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (socket_reset) begin
            r_cycle_cnt    <= '0;
            r_werr         <= 1'b0;
            r_kernel_start <= 1'b0;
            r_q            <= '0;
            for (int i = 0; i < NUM_ARGS; i++) r_args[i] <= '0;
        end else begin
            r_kernel_start <= w_start_go;
            if (w_rd) r_q <= w_rdata;

            if (w_start_go || w_clear_req) begin
                r_cycle_cnt <= '0;
            end else if (r_state == StRun && !kernel_done && r_cycle_cnt != 32'hFFFF_FFFF) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end

            if (w_clear_req) begin
                r_werr <= 1'b0;
            end else if (w_wr && w_arg_hit && r_state == StRun) begin
                r_werr <= 1'b1;
            end

            // ARG writes while the kernel runs are dropped so its inputs stay stable.
            for (int i = 0; i < NUM_ARGS; i++) begin
                if (w_wr && w_arg_hit && r_state != StRun && w_arg_off == ADDR_W'(i)) begin
                    r_args[i] <= cl_ctrl_d;
                end
            end
        end
    end

    assign cl_ctrl_q    = r_q;
    assign kernel_start = r_kernel_start;

    for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
        assign kernel_args[g*DATA_W +: DATA_W] = r_args[g];
    end

endmodule

// File: tb/tb_socket_ctrl_regs.sv
// Directed self-checking bench for socket_ctrl_regs: register access, start/done
// handshake, writes during RUN, simultaneous events and mid-run reset.
module tb_socket_ctrl_regs;

    logic         clk = 1'b0;
    logic         socket_reset;
    logic [11:0]  cl_ctrl_addr;
    logic         cl_ctrl_ce;
    logic         cl_ctrl_we;
    logic [31:0]  cl_ctrl_d;
    logic [31:0]  cl_ctrl_q;
    logic         cl_done;
    logic         kernel_start;
    logic         kernel_done;
    logic [255:0] kernel_args;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int start_base;
    logic [31:0] rd;

    socket_ctrl_regs #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .NUM_ARGS (8),
        .ARG_BASE (12'h010)
    ) dut (
        .clk          (clk),
        .socket_reset (socket_reset),
        .cl_ctrl_addr (cl_ctrl_addr),
        .cl_ctrl_ce   (cl_ctrl_ce),
        .cl_ctrl_we   (cl_ctrl_we),
        .cl_ctrl_d    (cl_ctrl_d),
        .cl_ctrl_q    (cl_ctrl_q),
        .cl_done      (cl_done),
        .kernel_start (kernel_start),
        .kernel_done  (kernel_done),
        .kernel_args  (kernel_args)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kernel_start === 1'b1) start_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        cl_ctrl_addr = a; cl_ctrl_d = v; cl_ctrl_we = 1'b1; cl_ctrl_ce = 1'b1;
        @(negedge clk);
        cl_ctrl_ce = 1'b0; cl_ctrl_we = 1'b0;
    endtask

    task automatic rdreg(input logic [11:0] a, output logic [31:0] v);
        @(negedge clk);
        cl_ctrl_addr = a; cl_ctrl_we = 1'b0; cl_ctrl_ce = 1'b1;
        @(negedge clk);
        cl_ctrl_ce = 1'b0;
        v = cl_ctrl_q;
    endtask

    initial begin
        socket_reset = 1'b1; cl_ctrl_addr = '0; cl_ctrl_ce = 1'b0; cl_ctrl_we = 1'b0;
        cl_ctrl_d = '0; kernel_done = 1'b0;
        repeat (3) @(negedge clk);
        socket_reset = 1'b0;

        // Reset state
        chk("reset_q", cl_ctrl_q, 0);
        chk("reset_cl_done", cl_done, 0);
        chk("reset_kstart", kernel_start, 0);
        chk("reset_args", kernel_args, 0);
        rdreg(12'h001, rd); chk("reset_status", rd, 32'h1);
        rdreg(12'h002, rd); chk("reset_cycle", rd, 0);

        // ARG write/readback
        wr(12'h010, 32'hDEADBEEF);
        wr(12'h017, 32'h12345678);
        wr(12'h011, 32'h3);
        rdreg(12'h010, rd); chk("arg0_rd", rd, 32'hDEADBEEF);
        rdreg(12'h017, rd); chk("arg7_rd", rd, 32'h12345678);
        chk("kargs_lo", kernel_args[31:0], 32'hDEADBEEF);
        chk("kargs_hi", kernel_args[255:224], 32'h12345678);
        wr(12'h011, 32'h99);
        chk("q_hold_over_write", cl_ctrl_q, 32'h12345678);
        wr(12'h011, 32'h3);
        rdreg(12'h00F, rd); chk("below_arg_base", rd, 0);
        rdreg(12'h018, rd); chk("above_arg_top", rd, 0);
        rdreg(12'h810, rd); chk("no_alias", rd, 0);
        rdreg(12'h000, rd); chk("ctrl_reads_zero", rd, 0);

        // kernel_done outside RUN is ignored
        @(negedge clk); kernel_done = 1'b1;
        @(negedge clk); kernel_done = 1'b0;
        chk("done_in_idle", cl_done, 0);

        // Start, 10 run cycles, done
        start_base = start_cnt;
        wr(12'h000, 32'h1);
        repeat (10) @(negedge clk);
        kernel_done = 1'b1;
        @(negedge clk); kernel_done = 1'b0;
        chk("start_one_pulse", start_cnt - start_base, 1);
        chk("cl_done_set", cl_done, 1);
        rdreg(12'h002, rd); chk("cycle_10", rd, 32'd10);
        rdreg(12'h001, rd); chk("status_done", rd, 32'h4);
        rdreg(12'h001, rd); chk("status_idle_after", rd, 32'h1);
        chk("cl_done_clr", cl_done, 0);

        // Writes during RUN
        start_base = start_cnt;
        wr(12'h000, 32'h1);
        wr(12'h011, 32'h5);
        wr(12'h000, 32'h1);
        chk("no_restart", start_cnt - start_base, 1);
        rdreg(12'h011, rd); chk("arg1_kept", rd, 32'h3);
        rdreg(12'h001, rd); chk("status_werr", rd, 32'hA);
        wr(12'h000, 32'h2);
        rdreg(12'h001, rd); chk("werr_cleared", rd, 32'h2);

        // kernel_done together with a start write in RUN
        @(negedge clk);
        cl_ctrl_addr = 12'h000; cl_ctrl_d = 32'h1; cl_ctrl_we = 1'b1; cl_ctrl_ce = 1'b1;
        kernel_done = 1'b1;
        @(negedge clk);
        cl_ctrl_ce = 1'b0; cl_ctrl_we = 1'b0; kernel_done = 1'b0;
        chk("done_wins_state", cl_done, 1);
        chk("done_wins_nostart", start_cnt - start_base, 1);
        rdreg(12'h7FF, rd); chk("unmapped_7ff", rd, 0);
        rdreg(12'h001, rd); chk("status_done2", rd, 32'h4);

        // Reset three cycles into RUN
        start_base = start_cnt;
        wr(12'h000, 32'h1);
        repeat (2) @(negedge clk);
        socket_reset = 1'b1;
        @(negedge clk); socket_reset = 1'b0;
        chk("rst_cl_done", cl_done, 0);
        chk("rst_args", kernel_args, 0);
        chk("rst_one_start", start_cnt - start_base, 1);
        rdreg(12'h001, rd); chk("rst_status", rd, 32'h1);
        rdreg(12'h002, rd); chk("rst_cycle", rd, 0);

        // Restart with clear+start, 2 run cycles
        wr(12'h000, 32'h3);
        repeat (2) @(negedge clk);
        kernel_done = 1'b1;
        @(negedge clk); kernel_done = 1'b0;
        chk("restart_pulse", start_cnt - start_base, 2);
        chk("restart_done", cl_done, 1);
        rdreg(12'h002, rd); chk("restart_cycle", rd, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
